// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// One transaction at a time over a req/gnt/rvalid bus; the response is routed
// back to whichever port owned the transaction.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned STREAK_W = 4;
    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_owner_d, w_owner_d_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [3:0]          r_mem_be, w_mem_be_nxt;
    logic [31:0]         r_mem_addr, w_mem_addr_nxt;
    logic [31:0]         r_mem_wdata, w_mem_wdata_nxt;
    logic [STREAK_W-1:0] r_streak, w_streak_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_discard, w_discard_nxt;
    logic                r_bus_err, w_bus_err_nxt;
    logic                r_to_if, w_to_if_nxt;
    logic                r_to_d, w_to_d_nxt;

    logic w_resp;
    logic w_timeout;
    logic w_flush_hit;
    logic w_pick_if;
    logic w_start;
    logic w_if_hit;
    logic w_d_hit;

    // Decode of the current cycle's bus and request situation
    assign w_resp      = (r_state == S_WAIT) && mem_rvalid;
    assign w_timeout   = (r_state != S_IDLE) && !w_resp
                         && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_flush_hit = if_flush && !r_owner_d && (r_state != S_IDLE);
    assign w_pick_if   = if_req && (!d_req || (r_streak == STREAK_W'(MAX_DATA_STREAK)));
    // The cycle after a timeout the requester still holds the aborted request
    assign w_start     = (r_state == S_IDLE) && (if_req || d_req) && !r_bus_err;

    // Response routing; a reset cycle kills any response immediately
    assign w_if_hit  = rst_n && w_resp && !r_owner_d && !r_discard && !if_flush;
    assign w_d_hit   = rst_n && w_resp && r_owner_d;
    assign if_rvalid = w_if_hit || (rst_n && r_to_if);
    assign d_rvalid  = w_d_hit || (rst_n && r_to_d);
    assign if_rdata  = w_if_hit ? mem_rdata : 32'h0;
    assign d_rdata   = w_d_hit ? mem_rdata : 32'h0;
    assign stall_if  = if_req && !if_rvalid;
    assign stall_mem = d_req && !d_rvalid;

    assign bus_err   = r_bus_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Next-state, bus payload, streak and timeout bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_d_nxt   = r_owner_d;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_be_nxt    = r_mem_be;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_streak_nxt    = r_streak;
        w_cnt_nxt       = r_cnt;
        w_discard_nxt   = r_discard;
        w_bus_err_nxt   = 1'b0;
        w_to_if_nxt     = 1'b0;
        w_to_d_nxt      = 1'b0;

        if (!if_req) begin
            w_streak_nxt = '0;
        end else if (w_start) begin
            if (w_pick_if) begin
                w_streak_nxt = '0;
            end else if (r_streak < STREAK_W'(MAX_DATA_STREAK)) begin
                w_streak_nxt = r_streak + STREAK_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt   = S_REQ;
                    w_mem_req_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_discard_nxt = 1'b0;
                    w_owner_d_nxt = !w_pick_if;
                    if (w_pick_if) begin
                        w_mem_we_nxt    = 1'b0;
                        w_mem_be_nxt    = 4'hF;
                        w_mem_addr_nxt  = if_addr;
                        w_mem_wdata_nxt = 32'h0;
                    end else begin
                        w_mem_we_nxt    = d_we;
                        w_mem_be_nxt    = d_be;
                        w_mem_addr_nxt  = d_addr;
                        w_mem_wdata_nxt = d_wdata;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_flush_hit) begin
                    w_discard_nxt = 1'b1;
                end
                if (w_timeout) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    w_to_d_nxt    = r_owner_d;
                    w_to_if_nxt   = !r_owner_d && !(r_discard || if_flush);
                    w_discard_nxt = 1'b0;
                end else if (r_state == S_REQ) begin
                    if (mem_gnt) begin
                        w_state_nxt   = S_WAIT;
                        w_mem_req_nxt = 1'b0;
                    end
                end else if (w_resp) begin
                    w_state_nxt   = S_IDLE;
                    w_discard_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_streak    <= '0;
            r_cnt       <= '0;
            r_discard   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_to_if     <= 1'b0;
            r_to_d      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner_d   <= w_owner_d_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_streak    <= w_streak_nxt;
            r_cnt       <= w_cnt_nxt;
            r_discard   <= w_discard_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_to_if     <= w_to_if_nxt;
            r_to_d      <= w_to_d_nxt;
        end
    end

endmodule
